sipo_collect4: RTL



---
 rtl/sipo_collect4_pkg.sv | 17 +
 rtl/d_ff_sync_re_en.sv | 42 ++++
 rtl/sipo_collect4.sv | 115 +++++++++++
 3 files changed

// File: rtl/sipo_collect4_pkg.sv
// Shared constants and NAND helper functions for the 4-bit serial collector.
package sipo_collect4_pkg;

    localparam int WORD_W = 4;
    localparam int CNT_W  = 2;

    // Two-input NAND, the basic gate every other function is built from.
    function automatic logic nand2(input logic a, input logic b);
        return ~(a & b);
    endfunction

    // Three-input NAND, used for the terminal-count decode.
    function automatic logic nand3(input logic a, input logic b, input logic c);
        return ~(a & b & c);
    endfunction

endpackage

// File: rtl/d_ff_sync_re_en.sv
// Falling-edge D flip-flop with synchronous active-high clear and a
// NAND-mux hold path when EN=0. The master latch is open while C is high
// and the slave takes its value on the falling edge, so the pair behaves
// as a single negative-edge register.
module d_ff_sync_re_en
    import sipo_collect4_pkg::*;
(
    input  logic D,
    input  logic C,
    input  logic RE,
    input  logic EN,
    output logic Q,
    output logic Qnot
);

    logic en_n;
    logic sel_d;
    logic sel_q;
    logic mux_o;
    logic re_n;
    logic clr_n;
    logic d_in;

    // 2:1 NAND mux: EN=1 selects D, EN=0 recirculates Q.
    assign en_n  = nand2(EN, EN);
    assign sel_d = nand2(EN, D);
    assign sel_q = nand2(en_n, Q);
    assign mux_o = nand2(sel_d, sel_q);

    // Clear dominates the mux output so RE=1 forces 0 regardless of EN.
    assign re_n  = nand2(RE, RE);
    assign clr_n = nand2(mux_o, re_n);
    assign d_in  = nand2(clr_n, clr_n);

    // Master/slave transfer on the falling edge of C.
    always_ff @(negedge C) begin
        Q <= d_in;
    end

    assign Qnot = ~Q;

endmodule

// File: rtl/sipo_collect4.sv
// Serial-to-parallel collector: shifts in D on enabled falling edges and
// transfers each complete 4-bit word to P with a one-cycle V pulse.
// The first-received bit of a word ends up in P[3].
module sipo_collect4
    import sipo_collect4_pkg::*;
(
    input  logic              C,
    input  logic              RE,
    input  logic              D,
    input  logic              EN,
    output logic [WORD_W-1:0] P,
    output logic              V,
    output logic [CNT_W-1:0]  CNT
);

    // Shift register: only the low three bits feed the next word; the top
    // bit is shifted out and never read.
    logic [2:0]        sr;
    logic              sr_top_unused;
    logic [2:0]        sr_qn_unused;
    logic              sr_top_qn_unused;
    logic [WORD_W-1:0] word_d;

    // Counter, output word and valid flop signals.
    logic [CNT_W-1:0]  cnt_qn;
    logic [CNT_W-1:0]  cnt_d;
    logic [WORD_W-1:0] p_qn_unused;
    logic              v_qn_unused;

    // Terminal-count decode signals.
    logic re_n;
    logic en_ok_n;
    logic en_ok;
    logic tc_n;
    logic tc;
    logic x_a;
    logic x_b;

    // Candidate word / shift-register next value: {SR[2:0], D}.
    assign word_d = {sr, D};

    genvar i;
    generate
        for (i = 0; i < 3; i++) begin : g_sr
            d_ff_sync_re_en u_sr (
                .D    (word_d[i]),
                .C    (C),
                .RE   (RE),
                .EN   (EN),
                .Q    (sr[i]),
                .Qnot (sr_qn_unused[i])
            );
        end
    endgenerate

    d_ff_sync_re_en u_sr_top (
        .D    (word_d[3]),
        .C    (C),
        .RE   (RE),
        .EN   (EN),
        .Q    (sr_top_unused),
        .Qnot (sr_top_qn_unused)
    );

    // Counter increment in NAND form: bit0 toggles, bit1 = bit1 XOR bit0.
    // 3 + 1 wraps to 0 with no extra logic.
    assign cnt_d[0] = cnt_qn[0];
    assign x_a      = nand2(CNT[1], cnt_qn[0]);
    assign x_b      = nand2(cnt_qn[1], CNT[0]);
    assign cnt_d[1] = nand2(x_a, x_b);

    generate
        for (i = 0; i < CNT_W; i++) begin : g_cnt
            d_ff_sync_re_en u_cnt (
                .D    (cnt_d[i]),
                .C    (C),
                .RE   (RE),
                .EN   (EN),
                .Q    (CNT[i]),
                .Qnot (cnt_qn[i])
            );
        end
    endgenerate

    // Word completes when CNT==3 AND EN AND NOT RE; reset wins a collision.
    assign re_n    = nand2(RE, RE);
    assign en_ok_n = nand2(EN, re_n);
    assign en_ok   = nand2(en_ok_n, en_ok_n);
    assign tc_n    = nand3(CNT[1], CNT[0], en_ok);
    assign tc      = nand2(tc_n, tc_n);

    generate
        for (i = 0; i < WORD_W; i++) begin : g_p
            d_ff_sync_re_en u_p (
                .D    (word_d[i]),
                .C    (C),
                .RE   (RE),
                .EN   (tc),
                .Q    (P[i]),
                .Qnot (p_qn_unused[i])
            );
        end
    endgenerate

    // Valid flop always loads, so it follows tc and drops after one edge.
    d_ff_sync_re_en u_v (
        .D    (tc),
        .C    (C),
        .RE   (RE),
        .EN   (1'b1),
        .Q    (V),
        .Qnot (v_qn_unused)
    );

endmodule
